in_port_vcbuf: RTL

Parametrised router input port. It demultiplexes incoming flits by their VC field into `VC_NUM` independent per-VC FIFOs of depth `DEPTH`. Each FIFO head is presented to the switch allocator, and a one-cycle credit pulse is returned upstream for every slot freed. It sits between the upstream link and the crossbar/allocator of each router port and replaces the fixed-width, fixed-depth input port.

---
 rtl/in_port_vcbuf.sv | 106 ++++++++++
 1 files changed

// File: rtl/in_port_vcbuf.sv
// Router input port: flits are steered by their VC field into per-VC FIFOs.
// Each FIFO head goes to the allocator, and every freed slot returns a one-cycle credit.
module in_port_vcbuf #(
    parameter int FLIT_W = 32,
    parameter int VC_NUM = 4,
    parameter int VC_LSB = 0,
    parameter int VC_W   = 3,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flit_valid,
    input  logic [FLIT_W-1:0]        flit_in,
    input  logic [VC_NUM-1:0]        pop,
    output logic [FLIT_W*VC_NUM-1:0] flit_out,
    output logic [VC_NUM-1:0]        out_valid,
    output logic [VC_NUM-1:0]        credit,
    output logic [CNT_W*VC_NUM-1:0]  occupancy,
    output logic [VC_NUM-1:0]        err_overflow,
    output logic                     err_bad_vc
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [VC_W:0] VC_LIMIT = (VC_W + 1)'(VC_NUM);

    logic [VC_W-1:0] vc;
    logic            bad_vc;
    logic            bad_vc_r;

    assign vc     = flit_in[VC_LSB +: VC_W];
    assign bad_vc = flit_valid && ({1'b0, vc} >= VC_LIMIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bad_vc_r <= 1'b0;
        end else if (bad_vc) begin
            bad_vc_r <= 1'b1;
        end
    end

    assign err_bad_vc = bad_vc_r;

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        localparam logic [VC_W-1:0] V_ID = VC_W'(v);

        logic [FLIT_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  count;
        logic              hit;
        logic              full;
        logic              do_pop;
        logic              do_push;
        logic              refuse;
        logic              credit_r;
        logic              ovf_r;

        assign hit     = flit_valid && (vc == V_ID);
        assign full    = (count == FULL_CNT);
        assign do_pop  = pop[v] && (count != '0);
        // A full FIFO still accepts when its head leaves in the same cycle.
        assign do_push = hit && (!full || do_pop);
        assign refuse  = hit && full && !do_pop;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                credit_r <= 1'b0;
                ovf_r    <= 1'b0;
            end else begin
                credit_r <= do_pop;
                if (refuse) begin
                    ovf_r <= 1'b1;
                end
                if (do_push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end

        // Storage is intentionally left out of reset; out_valid qualifies it.
        always_ff @(posedge clock) begin
            if (do_push) begin
                mem[wr_ptr] <= flit_in;
            end
        end

        assign flit_out[v*FLIT_W +: FLIT_W] = mem[rd_ptr];
        assign out_valid[v]                 = (count != '0);
        assign credit[v]                    = credit_r;
        assign occupancy[v*CNT_W +: CNT_W]  = count;
        assign err_overflow[v]              = ovf_r;
    end

endmodule
